// File: rtl/mdu_if.sv
// mdu_if: decode, multiplier and divider handshake bundle for the M-extension sequencer
interface mdu_if #(
  parameter int XLEN = 32
);
  logic            mul_inst;
  logic            div_inst;
  logic [2:0]      mulsel;
  logic [2:0]      divsel;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            mul_start;
  logic            div_start;
  logic            div_abort;
  logic [2:0]      unit_sel;
  logic [XLEN-1:0] unit_a;
  logic [XLEN-1:0] unit_b;
  logic [XLEN-1:0] mul_result;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  logic            stall_req;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            busy;
  modport master (
    output mul_inst, div_inst, mulsel, divsel, flush, op_a, op_b, mul_result, div_done, div_result,
    input  mul_start, div_start, div_abort, unit_sel, unit_a, unit_b, stall_req, result, result_valid, busy
  );
  modport slave (
    input  mul_inst, div_inst, mulsel, divsel, flush, op_a, op_b, mul_result, div_done, div_result,
    output mul_start, div_start, div_abort, unit_sel, unit_a, unit_b, stall_req, result, result_valid, busy
  );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle mul/div sequencer; define MDU_DIV_SHORTCUT_EN to resolve div-by-zero/overflow locally
module mdu_sequencer #(
  parameter int MUL_LAT = 2,
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave m
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  state_t          state;
  logic [3:0]      cnt;
  logic            special;
  logic [XLEN-1:0] special_val;
`ifdef MDU_DIV_SHORTCUT_EN
  logic signed_op, rem, b_zero, ovf;
  // RISC-V divide-by-zero and signed-overflow results, resolved without the divider
  always_comb begin
    signed_op   = m.divsel == 3'b001 || m.divsel == 3'b011;
    rem         = m.divsel == 3'b011 || m.divsel == 3'b100;
    b_zero      = m.op_b == '0;
    ovf         = signed_op && m.op_a == {1'b1, {(XLEN-1){1'b0}}} && m.op_b == '1;
    special     = b_zero || ovf;
    special_val = rem ? (b_zero ? m.op_a : '0) : (b_zero ? '1 : m.op_a);
  end
`else
  assign special     = 1'b0;
  assign special_val = '0;
`endif
  assign m.stall_req    = state == IDLE ? (m.mul_inst || m.div_inst) && !m.flush : state != DONE;
  assign m.result_valid = state == DONE && !m.flush;
  assign m.busy         = state != IDLE;
  // sequencer FSM: launch, wait for the unit, present the result for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      m.unit_sel  <= '0;
      m.unit_a    <= '0;
      m.unit_b    <= '0;
      m.result    <= '0;
      m.mul_start <= 1'b0;
      m.div_start <= 1'b0;
      m.div_abort <= 1'b0;
    end else begin
      m.mul_start <= 1'b0;
      m.div_start <= 1'b0;
      m.div_abort <= 1'b0;
      case (state)
        IDLE:
          if (!m.flush && (m.mul_inst || m.div_inst)) begin
            m.unit_a <= m.op_a;
            m.unit_b <= m.op_b;
            if (m.mul_inst) begin
              m.unit_sel  <= m.mulsel;
              m.mul_start <= 1'b1;
              cnt         <= 4'(MUL_LAT);
              state       <= MUL_WAIT;
            end else begin
              m.unit_sel <= m.divsel;
              if (special) begin
                m.result <= special_val;
                state    <= DONE;
              end else begin
                m.div_start <= 1'b1;
                state       <= DIV_WAIT;
              end
            end
          end
        MUL_WAIT: begin
          cnt <= cnt - 4'd1;
          if (m.flush) state <= IDLE;
          else if (cnt == 4'd1) begin
            m.result <= m.mul_result;
            state    <= DONE;
          end
        end
        DIV_WAIT:
          if (m.flush) begin
            m.div_abort <= 1'b1;
            state       <= IDLE;
          end else if (m.div_done) begin
            m.result <= m.div_result;
            state    <= DONE;
          end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed self-checking bench with an event-timeline model of the sequencer
module tb_mdu_sequencer;
  localparam int ML = 2;
`ifdef MDU_DIV_SHORTCUT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  localparam logic [31:0] SENT = 32'h5A5A_A5A5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mdu_if #(.XLEN(32)) m();
  mdu_sequencer #(.MUL_LAT(ML), .XLEN(32)) dut (.clk(clk), .rst(rst), .m(m));
  int cyc = 0, vectors = 0, miscompares = 0;
  int e_slo = -1, e_shi = -1, e_blo = -1, e_bhi = -1, e_ms = -1, e_ds = -1, e_ab = -1, e_rv = -1;
  logic [2:0]  e_sel;
  logic [31:0] e_a, e_b, e_val;
  logic [31:0] last_res = SENT;
  bit chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, act, exp);
    end
  endtask
  // architectural product: low word for MUL, high word of the signedness-adjusted 64-bit product otherwise
  function automatic logic [31:0] mul_model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (s == 3'b010 || s == 3'b011) ? 64'($signed(a)) : {32'b0, a};
    eb = (s == 3'b010) ? 64'($signed(b)) : {32'b0, b};
    p = ea * eb;
    return s == 3'b001 ? p[31:0] : p[63:32];
  endfunction
  function automatic bit is_special(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || ((s == 3'b001 || s == 3'b011) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction
  // RISC-V division semantics including the zero-divisor and overflow cases
  function automatic logic [31:0] div_model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    bit rem;
    rem = s == 3'b011 || s == 3'b100;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (s == 3'b001 || s == 3'b011) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
      return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return rem ? a % b : a / b;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_exp;
    e_slo = -1; e_shi = -1; e_blo = -1; e_bhi = -1;
    e_ms = -1; e_ds = -1; e_ab = -1; e_rv = -1;
  endtask
  task automatic idle_inputs;
    m.mul_inst = 1'b0; m.div_inst = 1'b0; m.flush = 1'b0; m.div_done = 1'b0;
    m.mulsel = 3'b0; m.divsel = 3'b0; m.op_a = '0; m.op_b = '0;
    m.mul_result = 32'hDEAD_BEEF; m.div_result = 32'hBAD0_C0DE;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_mul_start"}, 32'(m.mul_start), 0);
    chk({tag, "_div_start"}, 32'(m.div_start), 0);
    chk({tag, "_div_abort"}, 32'(m.div_abort), 0);
    chk({tag, "_result_valid"}, 32'(m.result_valid), 0);
    chk({tag, "_stall_req"}, 32'(m.stall_req), 0);
    chk({tag, "_busy"}, 32'(m.busy), 0);
    chk({tag, "_unit_sel"}, 32'(m.unit_sel), 0);
    chk({tag, "_unit_a"}, m.unit_a, 0);
    chk({tag, "_unit_b"}, m.unit_b, 0);
    chk({tag, "_result"}, m.result, 0);
  endtask
  // one operation: fl<0 none, fl==0 flush with the instruction, fl>0 flush fl cycles after the accept cycle
  task automatic run_op(input bit is_mul, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int dlat, input int fl);
    int a0, done_c, end_c;
    bit sc, wf;
    logic [31:0] v;
    a0 = cyc;
    v = is_mul ? mul_model(sel, a, b) : div_model(sel, a, b);
    sc = !is_mul && SC && is_special(sel, a, b);
    done_c = is_mul ? a0 + ML + 1 : sc ? a0 + 1 : a0 + 2 + dlat;
    wf = fl > 0 && a0 + fl < done_c;
    last_res = SENT;
    if (fl == 0) clear_exp();
    else begin
      e_slo = a0; e_shi = wf ? a0 + fl : done_c - 1;
      e_blo = a0 + 1; e_bhi = wf ? a0 + fl : done_c;
      e_ms = is_mul ? a0 + 1 : -1;
      e_ds = (!is_mul && !sc) ? a0 + 1 : -1;
      e_ab = (wf && !is_mul) ? a0 + fl + 1 : -1;
      e_rv = fl < 0 ? done_c : -1;
      e_sel = sel; e_a = a; e_b = b; e_val = v;
    end
    end_c = (fl > 0 && a0 + fl + 1 > done_c) ? a0 + fl + 1 : done_c;
    while (cyc <= end_c) begin
      m.mul_inst = is_mul && cyc == a0;
      m.div_inst = !is_mul && cyc == a0;
      m.mulsel = cyc == a0 ? sel : 3'($urandom);
      m.divsel = cyc == a0 ? sel : 3'($urandom);
      m.op_a = cyc == a0 ? a : $urandom;
      m.op_b = cyc == a0 ? b : $urandom;
      m.flush = fl >= 0 && cyc == a0 + fl;
      m.mul_result = (is_mul && cyc == a0 + ML) ? v : 32'hDEAD_BEEF;
      m.div_done = !is_mul && !sc && (wf ? cyc == a0 + fl : cyc == a0 + 1 + dlat);
      m.div_result = (!wf && cyc == a0 + 1 + dlat) ? v : 32'hBAD0_C0DE;
      tick();
    end
    idle_inputs();
    clear_exp();
  endtask
  // compare process: every output against the expected event timeline
  always @(negedge clk) if (chk_en) begin
    chk("stall_req", 32'(m.stall_req), 32'(cyc >= e_slo && cyc <= e_shi));
    chk("busy", 32'(m.busy), 32'(cyc >= e_blo && cyc <= e_bhi));
    chk("mul_start", 32'(m.mul_start), 32'(cyc == e_ms));
    chk("div_start", 32'(m.div_start), 32'(cyc == e_ds));
    chk("div_abort", 32'(m.div_abort), 32'(cyc == e_ab));
    chk("result_valid", 32'(m.result_valid), 32'(cyc == e_rv));
    if (cyc == e_rv) chk("result", m.result, e_val);
    if (cyc >= e_blo && cyc <= e_bhi) begin
      chk("unit_sel", 32'(m.unit_sel), 32'(e_sel));
      chk("unit_a", m.unit_a, e_a);
      chk("unit_b", m.unit_b, e_b);
    end
    if (m.result_valid) last_res = m.result;
    if (m.mul_inst && m.div_inst) begin
      miscompares++;
      $display("FAIL both_inst at cycle %0d: mul_inst and div_inst together", cyc);
    end
  end
  initial begin
    idle_inputs();
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    run_op(1, 3'b001, 32'd7, 32'd6, 0, -1);
    chk("mul_7x6", last_res, 32'd42);
    run_op(1, 3'b010, 32'hFFFF_FFFD, 32'd5, 0, -1);
    chk("mulh_m3x5", last_res, 32'hFFFF_FFFF);
    run_op(1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1);
    chk("mulhu_max", last_res, 32'hFFFF_FFFE);
    run_op(1, 3'b011, 32'h8000_0000, 32'd4, 0, -1);
    chk("mulhsu_min_x4", last_res, 32'hFFFF_FFFE);
    run_op(0, 3'b001, 32'd100, 32'd7, 33, -1);
    chk("div_100_7", last_res, 32'd14);
    run_op(0, 3'b011, 32'hFFFF_FFF9, 32'd2, 5, -1);
    chk("rem_m7_2", last_res, 32'hFFFF_FFFF);
    run_op(0, 3'b010, 32'hFFFF_FFF0, 32'h10, 4, -1);
    chk("divu_big", last_res, 32'h0FFF_FFFF);
    run_op(0, 3'b010, 32'h1234, 32'd0, 3, -1);
    chk("divu_by_zero", last_res, 32'hFFFF_FFFF);
    run_op(0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 3, -1);
    chk("rem_overflow", last_res, 32'h0);
    run_op(0, 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 3, -1);
    chk("div_overflow", last_res, 32'h8000_0000);
    run_op(0, 3'b100, 32'h55, 32'd0, 3, -1);
    chk("remu_by_zero", last_res, 32'h55);
    run_op(0, 3'b001, 32'd1000, 32'd3, 40, 6);
    chk("div_flush_no_result", last_res, SENT);
    run_op(1, 3'b001, 32'd3, 32'd3, 0, 0);
    chk("idle_flush_no_result", last_res, SENT);
    run_op(1, 3'b001, 32'd3, 32'd4, 0, 1);
    chk("mul_wait_flush_no_result", last_res, SENT);
    run_op(1, 3'b001, 32'd5, 32'd5, 0, ML + 1);
    chk("done_flush_no_result", last_res, SENT);
    run_op(1, 3'b001, 32'd9, 32'd9, 0, -1);
    chk("mul_after_flush", last_res, 32'd81);
    chk_en = 1'b0;
    m.mul_inst = 1'b1; m.mulsel = 3'b001; m.op_a = 32'd3; m.op_b = 32'd5;
    tick();
    idle_inputs();
    chk("pre_reset_mul_start", 32'(m.mul_start), 1);
    #2 rst = 1'b1;
    #1 chk_reset("async_reset");
    tick();
    rst = 1'b0;
    tick();
    clear_exp();
    chk_en = 1'b1;
    run_op(1, 3'b001, 32'd1, 32'd1, 0, -1);
    chk("mul_1x1_after_reset", last_res, 32'd1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
